// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. busy paces the upstream byte serialiser one byte at a time.
module uart_tx_byte #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       busy,
    output logic       tx,
    output logic       done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    // Sized for two stop bits in a single count so the stop period never wraps.
    localparam int CNT_W = $clog2(CLKS_PER_BIT * 2);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_byte: CLK_FREQ/BAUD must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_byte: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_tx_byte: PARITY must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_par;
    logic             r_busy;
    logic             r_tx;
    logic             r_done;

    logic w_accept;
    logic w_par;

    assign w_accept = send && !r_busy;
    // Parity is taken from the byte at acceptance; the shift register is consumed later.
    assign w_par    = (PARITY == 1) ? ~^data_in : ^data_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_state <= S_START;
                        r_shift <= data_in;
                        r_par   <= w_par;
                        r_cnt   <= BIT_LOAD;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DATA;
                        r_cnt   <= BIT_LOAD;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == '0) begin
                        if (r_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_cnt   <= BIT_LOAD;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_cnt   <= STOP_LOAD;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_cnt   <= BIT_LOAD;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_STOP;
                        r_cnt   <= STOP_LOAD;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign tx   = r_tx;
    assign done = r_done;

endmodule

// File: doc/uart_tx_byte.md
# uart_tx_byte

Byte-wide UART transmitter that serialises one 8-bit word per request onto an asynchronous serial line with start, data, optional parity and stop bits. It sits directly downstream of the byte serialiser feeding the debug/TB UART path. It consumes the serialiser's data byte and send strobe and returns a busy flag that paces the serialiser byte by byte.

## Interface
- CLK_FREQ, 50_000_000 — clk frequency in Hz.
- BAUD, 115_200 — line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, truncated), must be ≥ 2.
- PARITY, 0 — 0 none, 1 odd, 2 even.
- STOP_BITS, 1 — 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  8  byte to transmit, sampled only on acceptance.
- send  in  1  transmit request, level-sensitive, may stay high for several cycles.
- busy  out  1  high while a frame is in progress; requests are ignored while high.
- tx  out  1  serial line, idle high, registered.
- done  out  1  one-cycle pulse when a frame's last stop bit completes.

## Operation
- Acceptance: `send && !busy` at a rising edge latches data_in into the shift register and leaves IDLE.
  - `send` seen while busy=1 is ignored: no queuing and no error.
  - `send` held high after acceptance does not start a second frame. busy is already 1 from the next edge.
- FSM states are IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when PARITY=0.
  - Each non-IDLE bit period lasts exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded on each state or bit change.
- START drives tx=0.
- DATA sends 8 bits LSB first. A 3-bit index runs 0..7, and the register shifts right once per bit period.
- PARITY drives tx = ^byte for even parity, ~^byte for odd. The parity is computed over the latched byte.
- STOP drives tx=1 for STOP_BITS × CLKS_PER_BIT cycles.
- Frame length is (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Reset values: tx=1, busy=0, done=0, state IDLE, counters 0, shift register 0.
- Reset mid-frame: the frame is aborted. tx=1 and busy=0 from the edge after rst_n is sampled low. No done pulse is produced.
- Counter widths are sized by $clog2(CLKS_PER_BIT × 2) so that 2 stop bits fit in one count. There is no wrap-around inside a frame.

## Timing
- Accept at edge k. At edge k+1: busy=1 and tx=0 (start bit begins).
- Data bit i occupies cycles k+1+(1+i)·CLKS_PER_BIT through k+(2+i)·CLKS_PER_BIT.
- End of the last stop cycle: at edge k+1+N, where N is the frame length in cycles, busy goes 0 and done is 1 for exactly one cycle. tx stays 1.
- Back-to-back frames:
  - The earliest next acceptance is edge k+1+N, when busy is first seen 0. That gives tx=0 at k+2+N.
  - The inter-frame idle gap is therefore at least one cycle of tx=1 beyond the stop bits.
- Upstream compatibility:
  - The serialiser raises send one cycle after seeing busy=0 and keeps it high until it sees busy=1.
  - This block's registered busy guarantees each byte is accepted exactly once.
- data_in changes after acceptance have no effect on the frame in flight.

## Test plan
- Basic frame: CLKS_PER_BIT=10, PARITY=0, STOP_BITS=1; send 0xA5 for 1 cycle.
  - tx per 10-cycle slot: 0,1,0,1,0,0,1,0,1,1.
  - busy high for exactly 100 cycles; done pulses once at busy fall.
- Parity: send 0xA5 (four ones).
  - PARITY=2 gives a parity slot of 0.
  - PARITY=1 gives 1.
  - Frame length 110 cycles.
  - With STOP_BITS=2: 120 cycles, last 20 cycles tx=1.
- Held request: send held high for 30 cycles with 0x3C. Exactly one frame is sent; done pulses once. send asserted again only after done gives a second frame starting 1 cycle after acceptance.
- Request while busy: after accepting 0x55, pulse send with 0xFF mid-frame. The 0x55 frame is unaltered, there is no second frame, and busy is unaffected.
- Reset mid-frame: assert rst_n=0 during data bit 3.
  - Next edge: tx=1, busy=0, done=0.
  - After release, send 0x81 produces a clean full frame.
- Chain test: connect to the upstream 51-byte serialiser loaded with an incrementing pattern 0x00..0x32, MSB-first byte order.
  - The decoded tx stream is exactly 52 bytes with no loss or duplication.
  - The final byte sent is a 0x00 filler after the 51 data bytes.
  - 52 done pulses.
